fpu_addsub_arbiter: RTL
=======================

FPU_ADDSUB_ARBITER -- requirements
Module: fpu_addsub_arbiter

Interface
REQ-001 Parameter FORMAT_LENGTH, default 32: operand/result width.
REQ-002 Parameter DP_LATENCY, default 3, legal 1..15: cycles from dp_start to valid dp_result.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset; synchronous, active-low.
REQ-005 req0_valid  input  1  requester 0 has an operation pending.
REQ-006 req0_ready  output  1  requester 0 operation accepted this cycle.
REQ-007 req0_a, req0_b  input  FORMAT_LENGTH each  requester 0 IEEE-754 operands.
REQ-008 req0_sub  input  1  requester 0 op select: 0 = a+b, 1 = a-b.
REQ-009 req1_valid, req1_ready, req1_a, req1_b, req1_sub  same directions/widths as requester 0, for requester 1.
REQ-010 dp_a, dp_b  output  FORMAT_LENGTH each  operands to the shared add/sub datapath.
REQ-011 dp_add_sub  output  1  op select to the datapath.
REQ-012 dp_start  output  1  one-cycle launch pulse to the datapath.
REQ-013 dp_result  input  FORMAT_LENGTH  datapath result, valid DP_LATENCY cycles after dp_start.
REQ-014 res_valid  output  1  result available.
REQ-015 res_ready  input  1  consumer accepts result.
REQ-016 res_data  output  FORMAT_LENGTH  captured result.
REQ-017 res_id  output  1  requester index owning res_data.
REQ-018 busy  output  1  high in any state other than IDLE.

Function
REQ-019 FSM states IDLE, BUSY, DONE; one operation in flight at a time.
REQ-020 reqN_ready SHALL be combinational: high only in IDLE, only for the granted requester, only while that reqN_valid is high; never both high.
REQ-021 Arbitration round-robin: 1-bit pointer names the preferred requester; if only one valid, it is granted regardless of pointer.
REQ-022 On handshake (IDLE, reqN_valid & reqN_ready): capture a, b, sub, id N into internal registers; pointer <= other requester; load counter with DP_LATENCY; go to BUSY.
REQ-023 dp_a, dp_b, dp_add_sub driven from captured registers and held stable through BUSY.
REQ-024 dp_start high exactly in the first BUSY cycle.
REQ-025 Counter decrements each BUSY cycle; in the BUSY cycle with counter == 0, res_data <= dp_result, res_id <= captured id, state <= DONE.
REQ-026 Latency: handshake in cycle T -> dp_start in T+1 -> res_valid first high in T+2+DP_LATENCY (T+5 at default).
REQ-027 res_valid high exactly in DONE; res_data and res_id stable while res_valid & !res_ready.
REQ-028 DONE & res_ready -> IDLE next cycle; no request is accepted in the DONE cycle (one bubble; max throughput one op per DP_LATENCY+3 cycles).
REQ-029 Request inputs ignored outside IDLE; a requester holding valid keeps waiting without loss.
REQ-030 Withdrawal of reqN_valid in IDLE before handshake causes no state change.
REQ-031 No starvation: with both requesters continuously valid, grants strictly alternate.

Reset
REQ-032 rst_n low at a rising edge: state IDLE, pointer = requester 0, counter 0, all captured registers 0, res_data 0, res_id 0.
REQ-033 During and after reset: res_valid, dp_start, busy, req0_ready, req1_ready low (readies may go high in the first IDLE cycle after release); dp_a, dp_b, dp_add_sub 0.
REQ-034 Reset in BUSY or DONE discards the operation; no res_valid for it is ever produced.

Verification
REQ-035 Reset: hold rst_n low 2 cycles with both req valid -> all outputs 0, no ready asserted.
REQ-036 Single op: req0 a=0x3F000000, b=0x3EB00000, sub=0, handshake cycle 0 -> dp_start cycle 1 with dp_a=0x3F000000, dp_b=0x3EB00000, dp_add_sub=0; res_valid cycle 5, res_data = dp_result sampled in cycle 4, res_id=0.
REQ-037 Contention: both valid from reset release -> req0 granted first, req1 granted in IDLE after first result retires, then req0 again; readies never both high.
REQ-038 Backpressure: res_ready low 10 cycles in DONE -> res_valid, res_data, res_id unchanged; no ready asserted; release res_ready -> IDLE next cycle.
REQ-039 Reset mid-op: assert rst_n low in second BUSY cycle -> IDLE next cycle, busy 0, no res_valid in following 10 cycles.
REQ-040 Latency sweep: DP_LATENCY = 1 and 15 -> res_valid first high at T+3 and T+17 respectively.

Source files
------------

// File: rtl/fpu_addsub_arbiter.sv
// Two-requester round-robin front end for a single shared IEEE-754 add/sub datapath.
// One operation in flight: IDLE accepts, BUSY launches and waits DP_LATENCY cycles, DONE holds the result.
module fpu_addsub_arbiter #(
  parameter int FORMAT_LENGTH = 32,
  parameter int DP_LATENCY    = 3
) (
  input  logic                     clk,
  input  logic                     rst_n,

  input  logic                     req0_valid,
  output logic                     req0_ready,
  input  logic [FORMAT_LENGTH-1:0] req0_a,
  input  logic [FORMAT_LENGTH-1:0] req0_b,
  input  logic                     req0_sub,

  input  logic                     req1_valid,
  output logic                     req1_ready,
  input  logic [FORMAT_LENGTH-1:0] req1_a,
  input  logic [FORMAT_LENGTH-1:0] req1_b,
  input  logic                     req1_sub,

  output logic [FORMAT_LENGTH-1:0] dp_a,
  output logic [FORMAT_LENGTH-1:0] dp_b,
  output logic                     dp_add_sub,
  output logic                     dp_start,
  input  logic [FORMAT_LENGTH-1:0] dp_result,

  output logic                     res_valid,
  input  logic                     res_ready,
  output logic [FORMAT_LENGTH-1:0] res_data,
  output logic                     res_id,
  output logic                     busy
);

  localparam logic [3:0] LAT = 4'(DP_LATENCY);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state_q;
  state_t state_d;

  logic                     ptr_q;
  logic [3:0]               cnt_q;
  logic                     vld_p0;
  logic [FORMAT_LENGTH-1:0] op_a_p0;
  logic [FORMAT_LENGTH-1:0] op_b_p0;
  logic                     op_sub_p0;
  logic                     op_id_p0;
  logic [FORMAT_LENGTH-1:0] res_data_p1;
  logic                     res_id_p1;

  logic grant0;
  logic grant1;
  logic accept;
  logic in_idle;
  logic in_busy;
  logic last_busy;

  // Round-robin grant: pointer only matters when both requesters are valid.
  always_comb begin
    grant1 = req1_valid & (~req0_valid | ptr_q);
    grant0 = req0_valid & ~grant1;
  end

  assign in_idle    = (state_q == IDLE);
  assign in_busy    = (state_q == BUSY);
  assign last_busy  = in_busy & (cnt_q == 4'd0);

  // Readies are masked while reset is held so nothing looks accepted during reset.
  assign req0_ready = rst_n & in_idle & grant0;
  assign req1_ready = rst_n & in_idle & grant1;
  assign accept     = req0_ready | req1_ready;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept)    state_d = BUSY;
      BUSY:    if (last_busy) state_d = DONE;
      DONE:    if (res_ready) state_d = IDLE;
      default:                state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= 1'b0;
      cnt_q   <= 4'd0;
      vld_p0  <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        ptr_q  <= grant0;
        cnt_q  <= LAT;
        vld_p0 <= 1'b1;
      end else if (in_busy) begin
        vld_p0 <= 1'b0;
        if (cnt_q != 4'd0) cnt_q <= cnt_q - 4'd1;
      end
    end
  end

  // Stage p0: operands captured at the handshake, held for the whole operation.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      op_a_p0   <= '0;
      op_b_p0   <= '0;
      op_sub_p0 <= 1'b0;
      op_id_p0  <= 1'b0;
    end else if (accept) begin
      op_a_p0   <= grant1 ? req1_a   : req0_a;
      op_b_p0   <= grant1 ? req1_b   : req0_b;
      op_sub_p0 <= grant1 ? req1_sub : req0_sub;
      op_id_p0  <= grant1;
    end
  end

  // Stage p1: datapath result sampled in the last BUSY cycle, held through DONE.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      res_data_p1 <= '0;
      res_id_p1   <= 1'b0;
    end else if (last_busy) begin
      res_data_p1 <= dp_result;
      res_id_p1   <= op_id_p0;
    end
  end

  assign dp_a       = op_a_p0;
  assign dp_b       = op_b_p0;
  assign dp_add_sub = op_sub_p0;
  assign dp_start   = in_busy & vld_p0;

  assign res_valid  = (state_q == DONE);
  assign res_data   = res_data_p1;
  assign res_id     = res_id_p1;
  assign busy       = ~in_idle;

endmodule
